// File: rtl/fifo_defs_pkg.sv
// -----------------------------------------------------------------------------
// fifo_defs
//   Shared definitions for the parametrised FIFO.
//   - clog2()            : address-width helper usable in parameter/port decls
//   - FIFO_STD/FIFO_FWFT : read-mode selectors for the FWFT parameter
// -----------------------------------------------------------------------------
package fifo_defs;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Ceiling log2; clog2(1) = 0, clog2(16) = 4, clog2(17) = 5.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
//   WIDTH x DEPTH dual-port storage: synchronous write, asynchronous read,
//   intended to map onto distributed (LUT) RAM.
//   Ports:
//     clk    in   write clock
//     we     in   write enable
//     waddr  in   write address
//     wdata  in   write data
//     raddr  in   read address
//     rdata  out  read data (combinational from raddr)
// -----------------------------------------------------------------------------
module fifo_mem
    import fifo_defs::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; a reset port would block distributed-RAM
    // mapping, and occupancy is tracked by the controller anyway.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// -----------------------------------------------------------------------------
// param_fifo
//   Single-clock FIFO with occupancy count, almost-full/almost-empty
//   thresholds, sticky overflow/underflow flags, synchronous flush and a
//   selectable standard (registered) or first-word-fall-through read port.
//   Ports:
//     clk           in   system clock, rising edge
//     rst           in   synchronous active-low reset
//     clr           in   synchronous flush (pointers, count, error flags)
//     data_in       in   write data
//     wen / ren     in   write / read requests
//     data_out      out  read data (registered, or head-of-queue in FWFT)
//     full, empty   out  count == DEPTH / count == 0
//     almost_full   out  count >= AFULL_THRESH
//     almost_empty  out  count <= AEMPTY_THRESH
//     count         out  occupancy 0..DEPTH
//     overflow      out  sticky: a write was dropped
//     underflow     out  sticky: a read was attempted while empty
// -----------------------------------------------------------------------------
module param_fifo
    import fifo_defs::*;
#(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = FIFO_STD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [WIDTH-1:0]      data_in,
    input  logic                  wen,
    input  logic                  ren,
    output logic [WIDTH-1:0]      data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [clog2(DEPTH):0] count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("param_fifo: DEPTH must be a power of two >= 2");
    end
    if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_afull
        $error("param_fifo: AFULL_THRESH must be in 1..DEPTH");
    end
    if ((AEMPTY_THRESH < 0) || (AEMPTY_THRESH > DEPTH - 1)) begin : g_bad_aempty
        $error("param_fifo: AEMPTY_THRESH must be in 0..DEPTH-1");
    end
    if ((FWFT != FIFO_STD) && (FWFT != FIFO_FWFT)) begin : g_bad_mode
        $error("param_fifo: FWFT must be FIFO_STD or FIFO_FWFT");
    end

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] rd_data;

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // A full FIFO still accepts a write when a read frees a slot in the same
    // cycle. A flush suppresses both so no data moves while clearing.
    // NOTE: every always_comb output gets a default first so no latch forms.
    always_comb begin
        rd_acc    = ren && !empty && !clr;
        wr_acc    = wen && (!full || (ren && !empty)) && !clr && rst;
        count_nxt = count;
        if (wr_acc && !rd_acc) begin
            count_nxt = count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count - CW'(1);
        end
    end

    // Flags are registered from the next count so they line up with count.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count        <= count_nxt;
            empty        <= (count_nxt == '0);
            full         <= (count_nxt == DEPTH_C);
            almost_empty <= (count_nxt <= AEMPTY_C);
            almost_full  <= (count_nxt >= AFULL_C);
            overflow     <= overflow  || (wen && !wr_acc);
            underflow    <= underflow || (ren && empty);
        end
    end

    if (FWFT == FIFO_FWFT) begin : g_fwft
        assign data_out = rd_data;
    end else begin : g_std
        logic [WIDTH-1:0] dout_q;

        // Flush keeps the last read word; only reset clears it.
        always_ff @(posedge clk) begin
            if (!rst) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= rd_data;
            end
        end

        assign data_out = dout_q;
    end

endmodule

// File: tb/tb_param_fifo.sv
// -----------------------------------------------------------------------------
// tb_param_fifo
//   Directed bench for param_fifo: a standard-mode 8x16 instance and an FWFT
//   12x16 instance share clock and reset.
// -----------------------------------------------------------------------------
module tb_param_fifo;
    import fifo_defs::*;

    logic tb_clk;
    logic rst;

    // standard-mode instance
    logic       s_clr, s_wen, s_ren;
    logic [7:0] s_din, s_dout;
    logic       s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf;
    logic [4:0] s_count;

    // FWFT instance
    logic        f_clr, f_wen, f_ren;
    logic [11:0] f_din, f_dout;
    logic        f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
    logic [4:0]  f_count;

    int checks   = 0;
    int failures = 0;

    param_fifo #(
        .WIDTH (8),
        .DEPTH (16),
        .FWFT  (FIFO_STD)
    ) u_std (
        .clk          (tb_clk),
        .rst          (rst),
        .clr          (s_clr),
        .data_in      (s_din),
        .wen          (s_wen),
        .ren          (s_ren),
        .data_out     (s_dout),
        .full         (s_full),
        .empty        (s_empty),
        .almost_full  (s_afull),
        .almost_empty (s_aempty),
        .count        (s_count),
        .overflow     (s_ovf),
        .underflow    (s_unf)
    );

    param_fifo #(
        .WIDTH (12),
        .DEPTH (16),
        .FWFT  (FIFO_FWFT)
    ) u_fw (
        .clk          (tb_clk),
        .rst          (rst),
        .clr          (f_clr),
        .data_in      (f_din),
        .wen          (f_wen),
        .ren          (f_ren),
        .data_out     (f_dout),
        .full         (f_full),
        .empty        (f_empty),
        .almost_full  (f_afull),
        .almost_empty (f_aempty),
        .count        (f_count),
        .overflow     (f_ovf),
        .underflow    (f_unf)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    initial begin
        rst   = 1'b0;
        s_clr = 1'b0; s_wen = 1'b0; s_ren = 1'b0; s_din = '0;
        f_clr = 1'b0; f_wen = 1'b0; f_ren = 1'b0; f_din = '0;

        // reset, then idle
        step();
        rst = 1'b1;
        repeat (5) step();
        check("rst_count",  32'(s_count),  0);
        check("rst_empty",  32'(s_empty),  1);
        check("rst_aempty", 32'(s_aempty), 1);
        check("rst_full",   32'(s_full),   0);
        check("rst_afull",  32'(s_afull),  0);
        check("rst_ovf",    32'(s_ovf),    0);
        check("rst_unf",    32'(s_unf),    0);
        check("rst_dout",   32'(s_dout),   0);

        // fill 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            s_wen = 1'b1; s_din = 8'(i);
            step();
            check("fill_count",  32'(s_count),  32'(i));
            check("fill_empty",  32'(s_empty),  0);
            check("fill_aempty", 32'(s_aempty), (i <= 2)  ? 1 : 0);
            check("fill_afull",  32'(s_afull),  (i >= 14) ? 1 : 0);
            check("fill_full",   32'(s_full),   (i == 16) ? 1 : 0);
        end

        // write into full FIFO: dropped
        s_din = 8'hAA;
        step();
        s_wen = 1'b0;
        check("ovf_flag",  32'(s_ovf),   1);
        check("ovf_count", 32'(s_count), 16);
        check("ovf_full",  32'(s_full),  1);

        // flush
        s_clr = 1'b1;
        step();
        s_clr = 1'b0;
        check("clr_count", 32'(s_count), 0);
        check("clr_ovf",   32'(s_ovf),   0);
        check("clr_empty", 32'(s_empty), 1);
        check("clr_full",  32'(s_full),  0);
        check("clr_dout",  32'(s_dout),  0);

        // refill 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            s_wen = 1'b1; s_din = 8'(i);
            step();
        end
        check("refill_count", 32'(s_count), 16);

        // simultaneous read/write on a full FIFO for 20 cycles
        s_ren = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_din = 8'(8'h80 + i);
            step();
            check("rw_dout",  32'(s_dout),  (i < 16) ? 32'(i + 1) : 32'(8'h80 + i - 16));
            check("rw_count", 32'(s_count), 16);
            check("rw_ovf",   32'(s_ovf),   0);
        end
        s_wen = 1'b0;

        // drain: 0x84..0x93 across the pointer wrap
        for (int i = 0; i < 16; i++) begin
            step();
            check("drain_dout",   32'(s_dout),   32'(8'h84 + i));
            check("drain_count",  32'(s_count),  32'(15 - i));
            check("drain_aempty", 32'(s_aempty), (15 - i <= 2) ? 1 : 0);
            check("drain_empty",  32'(s_empty),  (i == 15) ? 1 : 0);
        end

        // read while empty
        step();
        s_ren = 1'b0;
        check("unf_flag",  32'(s_unf),   1);
        check("unf_dout",  32'(s_dout),  8'h93);
        check("unf_count", 32'(s_count), 0);

        // write+read while empty: write wins, read rejected
        s_wen = 1'b1; s_ren = 1'b1; s_din = 8'h55;
        step();
        s_wen = 1'b0; s_ren = 1'b0;
        check("wr_empty_count", 32'(s_count), 1);
        check("wr_empty_unf",   32'(s_unf),   1);
        check("wr_empty_dout",  32'(s_dout),  8'h93);
        s_ren = 1'b1;
        step();
        s_ren = 1'b0;
        check("rd55_dout",  32'(s_dout),  8'h55);
        check("rd55_empty", 32'(s_empty), 1);

        // FWFT: head visible without a read
        f_wen = 1'b1; f_din = 12'hABC;
        step();
        f_wen = 1'b0;
        check("fw_empty", 32'(f_empty), 0);
        check("fw_head",  32'(f_dout),  12'hABC);
        check("fw_count", 32'(f_count), 1);
        step();
        check("fw_hold",  32'(f_dout),  12'hABC);
        f_wen = 1'b1; f_din = 12'hDEF;
        step();
        f_wen = 1'b0;
        check("fw_head2",  32'(f_dout),  12'hABC);
        check("fw_count2", 32'(f_count), 2);
        f_ren = 1'b1;
        step();
        f_ren = 1'b0;
        check("fw_pop",       32'(f_dout),  12'hDEF);
        check("fw_pop_count", 32'(f_count), 1);
        f_wen = 1'b1; f_din = 12'h123;
        step();
        check("fw_count3", 32'(f_count), 2);

        // reset mid-stream with a write still requested
        f_din = 12'h777;
        rst = 1'b0;
        step();
        check("mrst_count",  32'(f_count),  0);
        check("mrst_empty",  32'(f_empty),  1);
        check("mrst_full",   32'(f_full),   0);
        check("mrst_aempty", 32'(f_aempty), 1);
        check("mrst_afull",  32'(f_afull),  0);
        check("mrst_ovf",    32'(f_ovf),    0);
        check("mrst_unf",    32'(f_unf),    0);
        check("mrst_s_dout", 32'(s_dout),   0);
        check("mrst_s_unf",  32'(s_unf),    0);
        f_wen = 1'b0;
        rst   = 1'b1;
        step();
        check("post_rst_count", 32'(f_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
Name: param_fifo

Overview:
Synchronous single-clock FIFO, parametrised in data width, depth and read mode; the successor to the fixed 8-bit buffer between the UART RX/TX path and the glitch-command parser. It adds occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) mode so consumers can peek at the head without popping it.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AFULL_THRESH, DEPTH-2, almost_full asserted when count >= AFULL_THRESH (1..DEPTH)
AEMPTY_THRESH, 2, almost_empty asserted when count <= AEMPTY_THRESH (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-low reset (rst=0 resets on next rising clk edge)
clr  in  1  synchronous flush: empties FIFO, clears error flags; memory contents untouched
data_in  in  WIDTH  write data
wen  in  1  write request
ren  in  1  read request
data_out  out  WIDTH  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AFULL_THRESH
almost_empty  out  1  count <= AEMPTY_THRESH
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a write was dropped
underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Reset (rst=0 at edge): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, data_out=0 (standard mode). rst has priority over clr; clr has priority over wen/ren.
- clr=1: same as reset except in standard mode data_out holds its value.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0; count is tracked separately and is never derived from pointer difference.
- Write accepted iff wen && (!full || ren_accepted). Accepted write: mem[wr_ptr] <= data_in, wr_ptr++.
- Read accepted iff ren && !empty. Accepted read: rd_ptr++.
- count next = count + write_accepted - read_accepted; all flags are registered from next count, so they are valid in the same cycle as count.
- Full with wen && ren: both accepted, count stays DEPTH, no overflow.
- Empty with wen && ren: write accepted, read rejected, underflow set, count becomes 1.
- wen && full && !ren: data dropped, overflow <= 1, holds until rst or clr.
- ren && empty: underflow <= 1, holds until rst or clr; data_out unchanged.
- Standard mode (FWFT=0): on an accepted read, data_out <= mem[rd_ptr] (1-cycle latency); otherwise data_out holds.
- FWFT mode (FWFT=1): data_out = mem[rd_ptr] combinationally; it is valid whenever empty=0 and advances the cycle after an accepted read. A write to an empty FIFO is visible on data_out, with empty=0, one cycle after wen. Value while empty is don't-care.
- Parameter checks: an elaboration-time error is raised if DEPTH is not a power of two or a threshold is out of range.

Decomposition:
- Shared package/header fifo_defs: clog2 helper function, FWFT mode constants (FIFO_STD=0, FIFO_FWFT=1).
- Sub-module fifo_mem: WIDTH x DEPTH dual-port RAM with synchronous write and asynchronous read, inferred as distributed RAM. param_fifo holds the pointers, count, flags and the output register.

Test Plan:
- Reset then idle 5 cycles -> count=0, empty=1, almost_empty=1, full=0, overflow=underflow=0, data_out=0.
- FWFT=0, DEPTH=16: write 0x01..0x10 back-to-back -> full=1 at count=16, almost_full=1 from count=14; read 16 times -> data_out 0x01..0x10, each one cycle after ren; empty=1 after last.
- Full FIFO, write 0xAA with ren=0 -> overflow=1, count=16, 0xAA never read out. Then pulse clr -> count=0, overflow=0, empty=1.
- Empty FIFO, ren alone -> underflow=1, data_out unchanged. Empty FIFO with wen+ren on 0x55 -> count=1, underflow=1, next read returns 0x55.
- Full FIFO with wen+ren for 20 cycles, writing 0x80..0x93 -> count stays 16, no overflow, output order continuous; checks pointer wrap.
- FWFT=1, WIDTH=12: write 0xABC to empty -> next cycle empty=0, data_out=0xABC with no ren. Pop -> next entry appears the following cycle. Assert rst=0 mid-stream -> all outputs reach their reset values on the next edge.
